dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU MEM stage and the 256-bit line-based data memory.
- Serves 32-bit word loads and stores from a 32-line by 32-byte array.
- On a miss it stalls the CPU, writes back a dirty victim line if needed, then refills the line through the memory enable/write/ack handshake.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_ctrl_if.sv | 28 ++
 rtl/dcache_sram.sv | 54 +++++
 rtl/dcache_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, types and helpers for the direct-mapped L1 data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;
    localparam int NUM_LINES  = 32;
    localparam int LINE_BYTES = 32;
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int OFS_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = ADDR_W - OFS_W - IDX_W;
    localparam int WSEL_W     = OFS_W - 2;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } state_t;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [LINE_W-1:0] line_t;

    // Line-aligned memory address built from a tag and an index.
    function automatic logic [ADDR_W-1:0] line_addr(input tag_t tag, input idx_t idx);
        return {tag, idx, {OFS_W{1'b0}}};
    endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU and line-memory bus of the L1 data cache. The cache is the slave,
// the CPU/memory environment is the master.
interface dcache_ctrl_if;
    import dcache_pkg::*;

    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [WORD_W-1:0] cpu_data_i;
    logic [WORD_W-1:0] cpu_data_o;
    logic              cpu_stall_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    line_t             mem_data_o;
    logic              mem_ack_i;
    line_t             mem_data_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_ack_i, mem_data_i,
        output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_ack_i, mem_data_i,
        input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage for the cache. Reads are combinational;
// stores write one word, refills write a whole line. Only valid/dirty reset.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  idx_t              rd_idx,
    output tag_t              rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output line_t             rd_line,
    input  logic              word_we,
    input  idx_t              word_idx,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0] word_data,
    input  logic              line_we,
    input  idx_t              line_idx,
    input  tag_t              line_tag,
    input  line_t             line_data
);
    tag_t                 tag_mem  [NUM_LINES];
    line_t                data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];

    // Line status: cleared by reset, refill makes a line valid and clean, stores dirty it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= {NUM_LINES{1'b0}};
            dirty <= {NUM_LINES{1'b0}};
        end else if (line_we) begin
            valid[line_idx] <= 1'b1;
            dirty[line_idx] <= 1'b0;
        end else if (word_we) begin
            dirty[word_idx] <= 1'b1;
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[line_idx]  <= line_tag;
            data_mem[line_idx] <= line_data;
        end else if (word_we) begin
            data_mem[word_idx][{word_sel, 5'd0} +: WORD_W] <= word_data;
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Define DCACHE_STATS_EN to add hit/miss counter outputs.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);
    state_t            state;
    tag_t              cpu_tag;
    idx_t              cpu_idx;
    logic [WSEL_W-1:0] cpu_wsel;
    tag_t              miss_tag;
    idx_t              miss_idx;
    tag_t              rd_tag;
    logic              rd_valid;
    logic              rd_dirty;
    line_t             rd_line;
    logic              hit;
    logic              hit_access;
    logic              miss_detect;
    logic              word_we;
    logic              line_we;
    logic              mem_enable;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    line_t             mem_data;
    logic              unused_addr_bits;

    assign cpu_tag          = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_idx          = bus.cpu_addr_i[OFS_W +: IDX_W];
    assign cpu_wsel         = bus.cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    assign bus.mem_enable_o = mem_enable;
    assign bus.mem_write_o  = mem_write;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_data_o   = mem_data;

    dcache_sram u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .rd_idx    (cpu_idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .word_idx  (cpu_idx),
        .word_sel  (cpu_wsel),
        .word_data (bus.cpu_data_i),
        .line_we   (line_we),
        .line_idx  (miss_idx),
        .line_tag  (miss_tag),
        .line_data (bus.mem_data_i)
    );

    // Hit compare plus the zero-wait CPU response (load data and stall).
    always_comb begin
        hit         = rd_valid && (rd_tag == cpu_tag);
        hit_access  = 1'b0;
        miss_detect = 1'b0;
        if ((state == ST_IDLE) && bus.cpu_req_i) begin
            hit_access  = hit;
            miss_detect = !hit;
        end else begin
            hit_access  = 1'b0;
            miss_detect = 1'b0;
        end
        word_we = hit_access && bus.cpu_we_i;
        line_we = (state == ST_ALLOCATE) && bus.mem_ack_i;
        if (hit_access) begin
            bus.cpu_data_o = rd_line[{cpu_wsel, 5'd0} +: WORD_W];
        end else begin
            bus.cpu_data_o = {WORD_W{1'b0}};
        end
        if (rst_i) begin
            bus.cpu_stall_o = 1'b0;
        end else begin
            bus.cpu_stall_o = (state != ST_IDLE) || miss_detect;
        end
    end

    // Miss sequencing FSM; memory request lines are registered and held until ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            miss_tag   <= {TAG_W{1'b0}};
            miss_idx   <= {IDX_W{1'b0}};
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_data   <= {LINE_W{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_detect) begin
                        miss_tag   <= cpu_tag;
                        miss_idx   <= cpu_idx;
                        mem_enable <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state     <= ST_WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= line_addr(rd_tag, cpu_idx);
                            mem_data  <= rd_line;
                        end else begin
                            state     <= ST_ALLOCATE;
                            mem_write <= 1'b0;
                            mem_addr  <= line_addr(cpu_tag, cpu_idx);
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state     <= ST_ALLOCATE;
                        mem_write <= 1'b0;
                        mem_addr  <= line_addr(miss_tag, miss_idx);
                    end
                end
                ST_ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        state      <= ST_REFILL;
                        mem_enable <= 1'b0;
                    end
                end
                ST_REFILL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_enable <= 1'b0;
                    mem_write  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit and miss event counters, wrapping at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
        end else begin
            if (hit_access) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (miss_detect) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed sequence, randomized traffic
// against a cache/memory model, and a reset-during-refill scenario.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    dcache_ctrl_if bus();
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    int           vectors = 0;
    int           miscompares = 0;
    txn_t         log_q[$];
    logic [255:0] mem_lines [logic [31:0]];
    logic         m_valid [32];
    logic         m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];
    bit           busy = 1'b1;
    bit           stray_ack_req = 1'b0;
    bit           force_long = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Backing memory: written lines, else a pattern derived from the address.
    function automatic logic [255:0] mem_fetch(input logic [31:0] a);
        logic [255:0] l;
        if (mem_lines.exists(a)) return mem_lines[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h5A5A_0000 ^ (a + 32'(w * 4));
        return l;
    endfunction

    // Memory responder: random latency, one-cycle ack, handshake rule checks.
    initial begin : responder
        int           cnt;
        int           lat;
        bit           prev_rd;
        bit           prev_wr;
        logic         snap_wr;
        logic [31:0]  snap_addr;
        logic [255:0] snap_data;
        cnt = 0; lat = 2; prev_rd = 1'b0; prev_wr = 1'b0;
        snap_wr = 1'b0; snap_addr = 32'd0; snap_data = 256'd0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = 256'd0;
        forever begin
            @(negedge clk_i); #1;
            if (rst_i) begin
                bus.mem_ack_i = 1'b0; cnt = 0; prev_rd = 1'b0; prev_wr = 1'b0;
            end else begin
                if (bus.mem_ack_i) begin
                    bus.mem_ack_i = 1'b0;
                    if (prev_rd) chk("enable_low_after_fetch_ack", 256'(bus.mem_enable_o), 256'd0);
                    if (prev_wr) chk("fetch_follows_writeback", 256'({bus.mem_enable_o, bus.mem_write_o}), 256'd2);
                    prev_rd = 1'b0; prev_wr = 1'b0; cnt = 0;
                end
                if (bus.mem_enable_o) begin
                    if (cnt == 0) begin
                        snap_wr = bus.mem_write_o; snap_addr = bus.mem_addr_o; snap_data = bus.mem_data_o;
                        lat = force_long ? 14 : $urandom_range(2, 14);
                        chk("mem_addr_aligned", 256'(bus.mem_addr_o[4:0]), 256'd0);
                    end else begin
                        chk("req_stable_write", 256'(bus.mem_write_o), 256'(snap_wr));
                        chk("req_stable_addr", 256'(bus.mem_addr_o), 256'(snap_addr));
                        if (snap_wr) chk("req_stable_data", bus.mem_data_o, snap_data);
                    end
                    cnt++;
                    if (cnt == lat) begin
                        bus.mem_ack_i = 1'b1;
                        if (snap_wr) begin
                            mem_lines[snap_addr] = snap_data;
                            bus.mem_data_i = {8{$urandom}};
                            prev_wr = 1'b1;
                            log_q.push_back('{1'b1, snap_addr, snap_data});
                        end else begin
                            bus.mem_data_i = mem_fetch(snap_addr);
                            prev_rd = 1'b1;
                            log_q.push_back('{1'b0, snap_addr, bus.mem_data_i});
                        end
                    end
                end else begin
                    cnt = 0;
                    if (stray_ack_req) begin
                        bus.mem_ack_i  = 1'b1;
                        bus.mem_data_i = {8{$urandom}};
                        stray_ack_req  = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle compare: reset values, and no memory traffic while the CPU is idle.
    initial begin : monitor
        forever begin
            @(negedge clk_i); #2;
            if (rst_i) begin
                chk("rst_mem_enable", 256'(bus.mem_enable_o), 256'd0);
                chk("rst_mem_write", 256'(bus.mem_write_o), 256'd0);
                chk("rst_mem_addr", 256'(bus.mem_addr_o), 256'd0);
                chk("rst_mem_data", bus.mem_data_o, 256'd0);
                chk("rst_cpu_data", 256'(bus.cpu_data_o), 256'd0);
                chk("rst_cpu_stall", 256'(bus.cpu_stall_o), 256'd0);
            end else if (!busy) begin
                chk("idle_no_mem_request", 256'(bus.mem_enable_o), 256'd0);
            end
        end
    end

    // One CPU access, predicted and checked from the cache model.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit abandon_in, output logic [31:0] rdata);
        int           idx;
        int           ws;
        int           cycles;
        int           exp_n;
        logic [21:0]  tag;
        bit           exp_hit;
        bit           exp_wb;
        bit           abandon;
        logic [31:0]  victim_addr;
        logic [31:0]  fill_addr;
        logic [255:0] victim_line;
        idx = int'(addr[9:5]); ws = int'(addr[4:2]); tag = addr[31:10];
        exp_hit     = m_valid[idx] && (m_tag[idx] == tag);
        exp_wb      = !exp_hit && m_valid[idx] && m_dirty[idx];
        abandon     = abandon_in && !exp_hit;
        victim_addr = {m_tag[idx], 5'(idx), 5'd0};
        victim_line = m_line[idx];
        fill_addr   = {tag, 5'(idx), 5'd0};
        rdata       = 32'd0;
        log_q.delete();
        busy = 1'b1;
        @(negedge clk_i);
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_data_i = wdata;
        #1;
        chk("stall_on_first_cycle", 256'(bus.cpu_stall_o), 256'(!exp_hit));
        if (!exp_hit) begin
            exp_n = exp_wb ? 2 : 1;
            if (abandon) begin
                repeat (2) @(negedge clk_i);
                bus.cpu_req_i = 1'b0;
                #1;
            end
            cycles = 0;
            while (bus.cpu_stall_o && cycles < 300) begin
                @(negedge clk_i); #1; cycles++;
            end
            chk("miss_completes_in_time", 256'(cycles < 300), 256'd1);
            chk("mem_txn_count", 256'(log_q.size()), 256'(exp_n));
            if (log_q.size() == exp_n) begin
                if (exp_wb) begin
                    chk("wb_is_write", 256'(log_q[0].wr), 256'd1);
                    chk("wb_addr", 256'(log_q[0].addr), 256'(victim_addr));
                    chk("wb_data", log_q[0].data, victim_line);
                end
                chk("fetch_is_read", 256'(log_q[exp_n-1].wr), 256'd0);
                chk("fetch_addr", 256'(log_q[exp_n-1].addr), 256'(fill_addr));
            end
            m_line[idx] = mem_fetch(fill_addr);
            m_tag[idx] = tag; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
        end
        if (!abandon) begin
            if (!we) begin
                chk("load_data", 256'(bus.cpu_data_o), 256'(m_line[idx][ws*32 +: 32]));
            end else begin
                m_line[idx][ws*32 +: 32] = wdata;
                m_dirty[idx] = 1'b1;
            end
            rdata = bus.cpu_data_o;
            @(posedge clk_i);
            @(negedge clk_i);
            bus.cpu_req_i = 1'b0;
        end
        busy = 1'b0;
    endtask

    initial begin : main
        logic [31:0] rd;
        logic [31:0] a;
        int          cycles;
        rst_i = 1'b1;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'd0; bus.cpu_data_i = 32'd0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 22'd0; m_line[i] = 256'd0;
        end
        repeat (3) @(negedge clk_i);
        #3;
        rst_i = 1'b0;
        busy = 1'b0;

        // Directed sequence with hand-computed expectations.
        do_access(1'b0, 32'h0000_0040, 32'd0, 1'b0, rd);
        chk("plan_fetch_count", 256'(log_q.size()), 256'd1);
        if (log_q.size() == 1) chk("plan_fetch_addr", 256'(log_q[0].addr), 256'h40);
        chk("plan_load40_word0", 256'(rd), 256'h5A5A_0040);
        do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, rd);
        chk("plan_store_hit_no_txn", 256'(log_q.size()), 256'd0);
        do_access(1'b0, 32'h0000_0044, 32'd0, 1'b0, rd);
        chk("plan_load44", 256'(rd), 256'hDEAD_BEEF);
        chk("plan_dirty_idx2", 256'(dut.u_sram.dirty[2]), 256'd1);
        do_access(1'b0, 32'h0000_0444, 32'd0, 1'b0, rd);
        chk("plan_evict_txn_count", 256'(log_q.size()), 256'd2);
        if (log_q.size() == 2) begin
            chk("plan_wb_addr", 256'(log_q[0].addr), 256'h40);
            chk("plan_wb_word1", 256'(log_q[0].data[63:32]), 256'hDEAD_BEEF);
            chk("plan_fill_addr", 256'(log_q[1].addr), 256'h440);
        end
        chk("plan_load444", 256'(rd), 256'h5A5A_0444);
`ifdef DCACHE_STATS_EN
        chk("stats_miss_cnt", 256'(miss_cnt), 256'd2);
        chk("stats_hit_cnt", 256'(hit_cnt), 256'd4);
`endif
        stray_ack_req = 1'b1;
        repeat (4) @(negedge clk_i);
        do_access(1'b0, 32'h0000_0444, 32'd0, 1'b0, rd);
        chk("stray_ack_no_txn", 256'(log_q.size()), 256'd0);
        chk("stray_ack_data", 256'(rd), 256'h5A5A_0444);

        // Randomized traffic over a few conflicting tags and indices.
        for (int n = 0; n < 300; n++) begin
            a = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 15) == 0), rd);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end

        // Reset five cycles into a refill fetch.
        busy = 1'b1; force_long = 1'b1;
        @(negedge clk_i);
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_3F80;
        cycles = 0;
        while (!(bus.mem_enable_o && !bus.mem_write_o) && cycles < 100) begin
            @(negedge clk_i); cycles++;
        end
        chk("reset_test_fetch_seen", 256'(cycles < 100), 256'd1);
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("reset_abort_enable", 256'(bus.mem_enable_o), 256'd0);
        chk("reset_abort_stall", 256'(bus.cpu_stall_o), 256'd0);
        bus.cpu_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        force_long = 1'b0;
        busy = 1'b0;
        do_access(1'b0, 32'h0000_3F80, 32'd0, 1'b0, rd);
        chk("reaccess_after_reset_txns", 256'(log_q.size()), 256'd1);
        chk("reaccess_after_reset_data", 256'(rd), 256'h5A5A_3F80);
        repeat (3) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
